aes_sbox_pipe: RTL and testbench

Parametrised, pipelined AES S-box array that substitutes `LANES` bytes per beat and supports either direction per beat: forward SubBytes or InvSubBytes. It sits between the round-state register and ShiftRows/InvShiftRows in the round datapath. A valid/ready handshake lets the round controller stall it without losing data. It supersedes the single-byte, forward-only, fixed-latency S-box.

---
 rtl/aes_pkg.sv | 43 ++++
 rtl/aes_sbox_lane.sv | 37 +++
 rtl/aes_sbox_pipe.sv | 130 +++++++++++++
 tb/tb_aes_sbox_pipe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES field arithmetic and affine helpers
package aes_pkg;

    localparam logic [7:0] AES_POLY   = 8'h1B;
    localparam logic [7:0] SBOX_FWD_C = 8'h63;
    localparam logic [7:0] SBOX_INV_C = 8'h05;

    typedef logic [7:0] byte_t;

    // multiply by x, reducing with x^8 + x^4 + x^3 + x + 1
    function automatic byte_t xtime8(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

    // shift-and-add GF(2^8) multiplier
    function automatic byte_t gf_mul8(input byte_t a, input byte_t b);
        byte_t p;
        byte_t t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime8(t);
        end
        return p;
    endfunction

    function automatic byte_t gf_sq8(input byte_t a);
        return gf_mul8(a, a);
    endfunction

    // forward affine: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
    function automatic byte_t aff_fwd(input byte_t b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ SBOX_FWD_C;
    endfunction

    // inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05
    function automatic byte_t aff_inv(input byte_t b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ SBOX_INV_C;
    endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// rtl/aes_sbox_lane.sv - one byte lane of combinational S-box logic split at the pipe cut points
module aes_sbox_lane
    import aes_pkg::*;
(
    input  logic       inv,
    input  logic [7:0] din,
    output logic [7:0] hi,
    output logic [7:0] lo,
    input  logic [7:0] mid_hi,
    input  logic [7:0] mid_lo,
    output logic [7:0] prod,
    input  logic       back_inv,
    input  logic [7:0] back_prod,
    output logic [7:0] dout
);
    logic [7:0] b;
    logic [7:0] x2, x4, x8, x16, x32, x64, x128;

    // front half: input affine (inverse mode only) and the two partial products of x^254
    assign b    = inv ? aff_inv(din) : din;
    assign x2   = gf_sq8(b);
    assign x4   = gf_sq8(x2);
    assign x8   = gf_sq8(x4);
    assign x16  = gf_sq8(x8);
    assign x32  = gf_sq8(x16);
    assign x64  = gf_sq8(x32);
    assign x128 = gf_sq8(x64);
    assign lo   = gf_mul8(gf_mul8(x2, x4), gf_mul8(x8, x16));
    assign hi   = gf_mul8(gf_mul8(x32, x64), x128);

    // middle: full inverse; zero input falls out as zero naturally
    assign prod = gf_mul8(mid_hi, mid_lo);

    // back half: forward mode applies the output affine, inverse mode passes the inverse
    assign dout = back_inv ? back_prod : aff_fwd(back_prod);

endmodule

// File: rtl/aes_sbox_pipe.sv
// rtl/aes_sbox_pipe.sv - LANES-wide pipelined forward/inverse S-box with valid/ready stalls
module aes_sbox_pipe
    import aes_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic               inv_i,
    input  logic [8*LANES-1:0] data_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [8*LANES-1:0] data_o,
    output logic               busy_o
);
    localparam int W = 8 * LANES;

    logic [PIPE_STAGES-1:0] vld;
    logic [PIPE_STAGES-1:0] src_vld;
    logic [PIPE_STAGES-1:0] ld;
    logic [PIPE_STAGES-1:0] en;
    logic                   chain;

    logic [W-1:0] f_hi, f_lo, m_hi, m_lo, m_prod, b_prod, b_out, out_q;
    logic         b_inv;

    if (LANES < 1 || LANES > 16) begin : g_bad_lanes
        $error("aes_sbox_pipe: LANES must be 1..16");
    end

    // stage s may load when it is empty or its successor is loading; last stage drains on ready_i
    always_comb begin
        chain      = ready_i;
        ld         = '0;
        src_vld    = '0;
        src_vld[0] = valid_i;
        for (int s = 1; s < PIPE_STAGES; s++) src_vld[s] = vld[s-1];
        for (int s = PIPE_STAGES - 1; s >= 0; s--) begin
            chain = chain | ~vld[s];
            ld[s] = chain;
        end
        en = ld & src_vld;
    end

    // stage valid bits: take the predecessor's valid when loading, otherwise hold
    always_ff @(posedge clk_i) begin
        if (rst_i) vld <= '0;
        else       vld <= en | (vld & ~ld);
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        aes_sbox_lane u_lane (
            .inv       (inv_i),
            .din       (data_i[8*k +: 8]),
            .hi        (f_hi[8*k +: 8]),
            .lo        (f_lo[8*k +: 8]),
            .mid_hi    (m_hi[8*k +: 8]),
            .mid_lo    (m_lo[8*k +: 8]),
            .prod      (m_prod[8*k +: 8]),
            .back_inv  (b_inv),
            .back_prod (b_prod[8*k +: 8]),
            .dout      (b_out[8*k +: 8])
        );
    end

    if (PIPE_STAGES == 1) begin : g_s1
        assign m_hi   = f_hi;
        assign m_lo   = f_lo;
        assign b_prod = m_prod;
        assign b_inv  = inv_i;
    end else if (PIPE_STAGES == 2 || PIPE_STAGES == 3) begin : g_front
        logic [W-1:0] s0_hi, s0_lo;
        logic         s0_inv;

        // cut after the partial products; the mode bit rides along
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                s0_hi  <= '0;
                s0_lo  <= '0;
                s0_inv <= 1'b0;
            end else if (en[0]) begin
                s0_hi  <= f_hi;
                s0_lo  <= f_lo;
                s0_inv <= inv_i;
            end
        end

        assign m_hi = s0_hi;
        assign m_lo = s0_lo;

        if (PIPE_STAGES == 2) begin : g_s2
            assign b_prod = m_prod;
            assign b_inv  = s0_inv;
        end else begin : g_s3
            logic [W-1:0] s1_prod;
            logic         s1_inv;

            // cut after the full inverse, before the output affine
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    s1_prod <= '0;
                    s1_inv  <= 1'b0;
                end else if (en[1]) begin
                    s1_prod <= m_prod;
                    s1_inv  <= s0_inv;
                end
            end

            assign b_prod = s1_prod;
            assign b_inv  = s1_inv;
        end
    end else begin : g_bad_stages
        $error("aes_sbox_pipe: PIPE_STAGES must be 1, 2 or 3");
    end

    // output register; holds its last value while no beat is loaded
    always_ff @(posedge clk_i) begin
        if (rst_i)                   out_q <= '0;
        else if (en[PIPE_STAGES-1])  out_q <= b_out;
    end

    assign data_o  = out_q;
    assign valid_o = vld[PIPE_STAGES-1];
    assign ready_o = ld[0];
    assign busy_o  = |vld;

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// tb/tb_aes_sbox_pipe.sv - directed checks of aes_sbox_pipe across lane and stage configurations
module tb_aes_sbox_pipe;

    logic         clk = 1'b0;
    logic         rst, valid, inv, rdy;
    logic [31:0]  din4;
    logic [127:0] din16;

    logic         r4, vo4, bz4;
    logic [31:0]  do4;
    logic         ra, voa, bza, rb, vob, bzb, rc, voc, bzc;
    logic [127:0] doa, dob;
    logic [7:0]   doc;

    int nchecks = 0;
    int nerr    = 0;

    logic [7:0] sbox [256];
    logic [7:0] invtab [256];

    int          lat4, lata, latb, latc;
    logic [31:0] cap4;
    logic [127:0] capa, capb;
    logic [7:0]  capc;

    typedef struct {
        logic [31:0] d;
        logic        m;
        logic [31:0] e;
    } vec_t;
    vec_t vecs[6];

    logic [31:0] in_alt [256];
    logic [31:0] exp_alt [256];

    always #5 clk = ~clk;

    aes_sbox_pipe #(.LANES(4), .PIPE_STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(r4), .inv_i(inv),
        .data_i(din4), .valid_o(vo4), .ready_i(rdy), .data_o(do4), .busy_o(bz4));
    aes_sbox_pipe #(.LANES(16), .PIPE_STAGES(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ra), .inv_i(inv),
        .data_i(din16), .valid_o(voa), .ready_i(rdy), .data_o(doa), .busy_o(bza));
    aes_sbox_pipe #(.LANES(16), .PIPE_STAGES(3)) dut_b (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(rb), .inv_i(inv),
        .data_i(din16), .valid_o(vob), .ready_i(rdy), .data_o(dob), .busy_o(bzb));
    aes_sbox_pipe #(.LANES(1), .PIPE_STAGES(3)) dut_c (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(rc), .inv_i(inv),
        .data_i(din16[7:0]), .valid_o(voc), .ready_i(rdy), .data_o(doc), .busy_o(bzc));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fwd4(input logic [31:0] d);
        return {sbox[d[31:24]], sbox[d[23:16]], sbox[d[15:8]], sbox[d[7:0]]};
    endfunction

    function automatic logic [31:0] bp_in(input int i);
        logic [7:0] b;
        b = 8'(8'h30 + i * 37);
        return {b ^ 8'hAA, b ^ 8'h55, ~b, b};
    endfunction

    // one isolated beat into every instance; records first-output latency and data
    task automatic beat(input logic [127:0] d, input logic m);
        lat4 = 0; lata = 0; latb = 0; latc = 0;
        din16 = d; din4 = d[31:0]; inv = m; valid = 1'b1;
        @(posedge clk); #1 valid = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (vo4 && lat4 == 0) begin lat4 = n; cap4 = do4; end
            if (voa && lata == 0) begin lata = n; capa = doa; end
            if (vob && latb == 0) begin latb = n; capb = dob; end
            if (voc && latc == 0) begin latc = n; capc = doc; end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [127:0] exp16;
        logic [7:0]   x;
        int           got, first, last, stalls, sent;
        logic         held;
        logic [31:0]  prev;

        sbox = '{
            8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
            8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
            8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
            8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
            8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
            8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
            8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
            8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
            8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
            8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
            8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
            8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
            8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
            8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
            8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
            8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
        for (int i = 0; i < 256; i++) invtab[sbox[i]] = 8'(i);

        vecs[0] = '{32'h13530100, 1'b0, 32'h7DED7C63};
        vecs[1] = '{32'h7DED7C63, 1'b1, 32'h13530100};
        vecs[2] = '{32'h00000000, 1'b1, 32'h52525252};
        vecs[3] = '{32'hFFFEFDFC, 1'b0, 32'h16BB54B0};
        vecs[4] = '{32'h16BB54B0, 1'b1, 32'hFFFEFDFC};
        vecs[5] = '{32'h00000000, 1'b0, 32'h63636363};

        // reset, with valid_i already high while reset is asserted
        rst = 1'b1; valid = 1'b1; inv = 1'b0; rdy = 1'b1;
        din4 = 32'hFFFFFFFF; din16 = '1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; valid = 1'b0;
        @(negedge clk);
        check("reset_valid_o", vo4, 0);
        check("reset_busy_o", bz4, 0);
        check("reset_data_o", do4, 0);
        check("reset_ready_o", r4, 1);
        check("reset_data_o_16", doa, 0);
        repeat (3) @(negedge clk);
        check("reset_no_ghost_beat", {vo4, voa, vob, voc}, 0);
        @(posedge clk); #1;

        // directed vectors, 4 lanes / 2 stages
        for (int i = 0; i < 6; i++) begin
            beat({96'h0, vecs[i].d}, vecs[i].m);
            check($sformatf("vec%0d_data", i), cap4, vecs[i].e);
            check($sformatf("vec%0d_latency", i), lat4, 2);
        end

        // row 0 of the S-box through every configuration
        for (int k = 0; k < 16; k++) exp16[8*k +: 8] = sbox[k];
        beat(128'h0F0E0D0C0B0A09080706050403020100, 1'b0);
        check("sweep_l4p2_data", cap4, 32'h7B777C63);
        check("sweep_l4p2_latency", lat4, 2);
        check("sweep_l16p1_data", capa, exp16);
        check("sweep_l16p1_latency", lata, 1);
        check("sweep_l16p3_data", capb, exp16);
        check("sweep_l16p3_latency", latb, 3);
        check("sweep_l1p3_data", capc, 8'h63);
        check("sweep_l1p3_latency", latc, 3);
        beat(128'h0, 1'b1);
        check("sweep_l1p3_inv0", capc, 8'h52);
        check("sweep_l16p1_inv0", capa, {16{8'h52}});

        // 256 back-to-back beats with alternating mode; odd beats undo lanes 2/3 of the even beat
        for (int j = 0; j < 256; j++) begin
            x = 8'(j);
            if (j % 2 == 0) begin
                in_alt[j]  = {x + 8'd1, x, x ^ 8'h01, x};
                exp_alt[j] = {sbox[x + 8'd1], sbox[x], sbox[x ^ 8'h01], sbox[x]};
            end else begin
                in_alt[j]  = {sbox[x], sbox[x - 8'd1], x ^ 8'h01, x};
                exp_alt[j] = {x, x - 8'd1, invtab[x ^ 8'h01], invtab[x]};
            end
        end
        got = 0; first = 0; last = 0; stalls = 0;
        fork
            begin
                for (int j = 0; j < 256; j++) begin
                    din4 = in_alt[j]; inv = j[0]; valid = 1'b1;
                    @(negedge clk);
                    if (!r4) stalls++;
                    @(posedge clk); #1;
                end
                valid = 1'b0;
            end
            begin
                for (int c = 0; c < 400 && got < 256; c++) begin
                    @(negedge clk);
                    if (vo4) begin
                        check($sformatf("alt_beat%0d", got), do4, exp_alt[got]);
                        if (got == 0) first = c;
                        last = c;
                        got++;
                    end
                end
            end
        join
        check("alt_count", got, 256);
        check("alt_no_bubbles", last - first, 255);
        check("alt_no_input_stall", stalls, 0);
        repeat (6) @(posedge clk); #1;

        // backpressure: ready_i low for 5 cycles in the middle of an 8-beat stream
        got = 0; sent = 0; held = 1'b0; prev = '0; inv = 1'b0;
        fork
            begin
                for (int c = 0; c < 60 && sent < 8; c++) begin
                    din4 = bp_in(sent); valid = 1'b1;
                    @(negedge clk);
                    held = held;
                    if (r4) begin
                        @(posedge clk); #1 sent++;
                    end else begin
                        @(posedge clk); #1;
                    end
                end
                valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 rdy = 1'b0;
                repeat (5) @(posedge clk);
                #1 rdy = 1'b1;
            end
            begin
                for (int c = 0; c < 60 && got < 8; c++) begin
                    @(negedge clk);
                    if (vo4 && rdy) begin
                        check($sformatf("bp_beat%0d", got), do4, fwd4(bp_in(got)));
                        got++;
                        held = 1'b0;
                    end else if (!rdy) begin
                        check("bp_ready_low_when_full", {vo4, r4}, 2'b10);
                        if (held) check("bp_data_stable", do4, prev);
                        prev = do4;
                        held = 1'b1;
                    end
                end
            end
        join
        check("bp_sent", sent, 8);
        check("bp_received", got, 8);
        @(negedge clk);
        check("bp_no_duplicate", vo4, 0);
        repeat (6) @(posedge clk); #1;

        // reset with two beats in flight
        rdy = 1'b0; inv = 1'b0; valid = 1'b1; din4 = 32'h11223344;
        @(posedge clk); #1 din4 = 32'h55667788;
        @(posedge clk); #1 valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midreset_valid_o", vo4, 0);
        check("midreset_data_o", do4, 0);
        check("midreset_ready_o", r4, 1);
        check("midreset_busy_o", bz4, 0);
        @(posedge clk); #1 rdy = 1'b1;
        beat({96'h0, 32'h00000053}, 1'b0);
        check("midreset_fresh_data", cap4, 32'h636363ED);
        check("midreset_fresh_latency", lat4, 2);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
